u_game_judge: RTL

- Receiving end of the note lane: consumes the target-LED occupancy and lane step pulse from the note shifter plus the raw player button.
- Judges each note that reaches the target slot as PERFECT, GOOD or MISS, and accumulates score and combo for the 7-segment/score display path.
- Sits between the note lane/button inputs and the display/sound blocks.

---
 rtl/u_game_pkg.sv | 20 ++
 rtl/u_btn_debounce.sv | 46 ++++
 rtl/u_game_judge.sv | 119 +++++++++++
 3 files changed

// File: rtl/u_game_pkg.sv
// Shared judge codes, FSM encoding and counter widths for the rhythm-game judge path.
package u_game_pkg;

  localparam int unsigned SCORE_W = 14;
  localparam int unsigned COMBO_W = 7;
  localparam int unsigned JUDGE_W = 2;
  localparam int unsigned WIN_W   = 16;

  localparam logic [JUDGE_W-1:0] JUDGE_NONE    = 2'd0;
  localparam logic [JUDGE_W-1:0] JUDGE_PERFECT = 2'd1;
  localparam logic [JUDGE_W-1:0] JUDGE_GOOD    = 2'd2;
  localparam logic [JUDGE_W-1:0] JUDGE_MISS    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WINDOW = 2'd1,
    ST_DONE   = 2'd2
  } judge_state_e;

endpackage

// File: rtl/u_btn_debounce.sv
// Button synchroniser + tick-based debouncer; emits a one-cycle pulse on an accepted press.
module u_btn_debounce #(
  parameter int unsigned DEBOUNCE_MS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned CNT_W = (DEBOUNCE_MS < 2) ? 1 : $clog2(DEBOUNCE_MS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;

  // Level is accepted on the DEBOUNCE_MS-th tick of continuous disagreement.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      o_press <= 1'b0;
    end else begin
      sync_q1 <= i_btn;
      sync_q2 <= sync_q1;
      o_press <= 1'b0;
      if (sync_q2 == level_q) begin
        cnt_q <= '0;
      end else if (i_tick) begin
        if (cnt_q == CNT_LAST) begin
          cnt_q   <= '0;
          level_q <= sync_q2;
          o_press <= sync_q2;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/u_game_judge.sv
// Note judge: classifies each note reaching the target slot and keeps score/combo.
module u_game_judge
  import u_game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned PERFECT_MS  = 50,
  parameter int unsigned PERFECT_PTS = 10,
  parameter int unsigned GOOD_PTS    = 5,
  parameter int unsigned SCORE_MAX   = 9999,
  parameter int unsigned COMBO_MAX   = 99
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_tick,
  input  logic               i_note_step,
  input  logic               i_is_target,
  input  logic               i_btn,
  input  logic               i_clear,
  output logic [JUDGE_W-1:0] o_judge,
  output logic               o_hit_pulse,
  output logic               o_miss_pulse,
  output logic [SCORE_W-1:0] o_score,
  output logic [COMBO_W-1:0] o_combo
);

  localparam int unsigned SUM_W = SCORE_W + 1;
  localparam logic [WIN_W-1:0] WIN_MAX = {WIN_W{1'b1}};

  logic               press;
  logic               eval_q;
  judge_state_e       state_q;
  logic [WIN_W-1:0]   win_ms_q;
  logic [JUDGE_W-1:0] res_c;
  logic [SUM_W-1:0]   score_sum_c;
  logic [SCORE_W-1:0] score_c;
  logic [COMBO_W-1:0] combo_c;

  u_btn_debounce #(
    .DEBOUNCE_MS(DEBOUNCE_MS)
  ) u_btn (
    .clk    (clk),
    .rst    (rst),
    .i_tick (i_tick),
    .i_btn  (i_btn),
    .o_press(press)
  );

  // A press in the window judges the current note before a coincident eval is considered.
  always_comb begin
    res_c = JUDGE_NONE;
    case (state_q)
      ST_IDLE: begin
        if (press) res_c = JUDGE_MISS;
      end
      ST_WINDOW: begin
        if (press) begin
          res_c = (win_ms_q < WIN_W'(PERFECT_MS)) ? JUDGE_PERFECT : JUDGE_GOOD;
        end else if (eval_q) begin
          res_c = JUDGE_MISS;
        end
      end
      default: res_c = JUDGE_NONE;
    endcase
  end

  // Saturating score/combo increments for a hit.
  always_comb begin
    score_sum_c = {1'b0, o_score} +
                  ((res_c == JUDGE_PERFECT) ? SUM_W'(PERFECT_PTS) : SUM_W'(GOOD_PTS));
    score_c     = (score_sum_c > SUM_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                    : score_sum_c[SCORE_W-1:0];
    combo_c     = (o_combo >= COMBO_W'(COMBO_MAX)) ? COMBO_W'(COMBO_MAX)
                                                   : o_combo + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      eval_q       <= 1'b0;
      state_q      <= ST_IDLE;
      win_ms_q     <= '0;
      o_judge      <= JUDGE_NONE;
      o_hit_pulse  <= 1'b0;
      o_miss_pulse <= 1'b0;
      o_score      <= '0;
      o_combo      <= '0;
    end else begin
      eval_q       <= i_note_step;
      o_hit_pulse  <= 1'b0;
      o_miss_pulse <= 1'b0;

      if (eval_q) begin
        state_q  <= i_is_target ? ST_WINDOW : ST_IDLE;
        win_ms_q <= '0;
      end else if ((state_q == ST_WINDOW) && press) begin
        state_q <= ST_DONE;
      end else if ((state_q == ST_WINDOW) && i_tick && (win_ms_q != WIN_MAX)) begin
        win_ms_q <= win_ms_q + 1'b1;
      end

      // New-game clear wins over any coincident judgement.
      if (i_clear) begin
        o_judge <= JUDGE_NONE;
        o_score <= '0;
        o_combo <= '0;
      end else if (res_c != JUDGE_NONE) begin
        o_judge <= res_c;
        if (res_c == JUDGE_MISS) begin
          o_miss_pulse <= 1'b1;
          o_combo      <= '0;
        end else begin
          o_hit_pulse <= 1'b1;
          o_score     <= score_c;
          o_combo     <= combo_c;
        end
      end
    end
  end

endmodule
